// File: rtl/acquisition_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : acquisition_sequencer
// Brief    : Arms on request, waits for a trigger, then drives decimated
//            write strobes for one ADC window into the BRAM writer.
// Revision : 1.0 - initial release
// ============================================================================
module acquisition_sequencer #(
    parameter int DECIM_W = 16,
    parameter int LEN_W   = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_arm,
    input  logic               i_abort,
    input  logic [1:0]         i2_trig_mode,
    input  logic               i_ext_trigger,
    input  logic [13:0]        i14_data,
    input  logic [13:0]        i14_trig_level,
    input  logic [DECIM_W-1:0] i16_decimation,
    input  logic [LEN_W-1:0]   i10_window_length,
    input  logic               i_readout_done,
    output logic               o_we,
    output logic               o_acquire_window,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_cfg_err,
    output logic [LEN_W-1:0]   or10_sample_count
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ARMED   = 3'd1;
    localparam logic [2:0] c_CAPTURE = 3'd2;
    localparam logic [2:0] c_FLUSH   = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam logic [1:0] c_MODE_IMM  = 2'b00;
    localparam logic [1:0] c_MODE_RISE = 2'b01;
    localparam logic [1:0] c_MODE_FALL = 2'b10;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [1:0]         r_mode;
    logic [13:0]        r_level;
    logic [DECIM_W-1:0] r_dec;
    logic [LEN_W-1:0]   r_len;
    logic [13:0]        r_prev;
    logic [DECIM_W-1:0] r_dec_cnt;
    logic [LEN_W-1:0]   r_count;

    logic               w_we;
    logic               w_aw;
    logic               w_trig;
    logic               w_last;
    logic [DECIM_W-1:0] w_dec_last;
    logic signed [13:0] w_cur;
    logic signed [13:0] w_prev;
    logic signed [13:0] w_lvl;

    assign w_cur  = i14_data;
    assign w_prev = r_prev;
    assign w_lvl  = r_level;

    // Decimation of 0 behaves as 1, so the counter period is max(dec,1).
    assign w_dec_last = (r_dec <= DECIM_W'(1)) ? '0 : (r_dec - DECIM_W'(1));
    assign w_last     = (r_count == (r_len - LEN_W'(1)));

    always_comb begin
        w_trig = 1'b0;
        case (r_mode)
            c_MODE_IMM:  w_trig = 1'b1;
            c_MODE_RISE: w_trig = (w_prev < w_lvl) && (w_cur >= w_lvl);
            c_MODE_FALL: w_trig = (w_prev > w_lvl) && (w_cur <= w_lvl);
            default:     w_trig = i_ext_trigger;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_aw         = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (i_arm && (i10_window_length != '0)) begin
                    w_next_state = c_ARMED;
                end
            end
            c_ARMED: begin
                if (i_abort) begin
                    w_next_state = c_IDLE;
                end else if (w_trig) begin
                    w_next_state = c_CAPTURE;
                end
            end
            c_CAPTURE: begin
                w_we = (r_dec_cnt == '0);
                w_aw = w_we && (r_count == '0);
                // A final strobe beats a coincident abort.
                if (w_we && w_last) begin
                    w_next_state = c_DONE;
                end else if (i_abort) begin
                    w_next_state = c_FLUSH;
                end
            end
            c_FLUSH: begin
                w_we = 1'b1;
                if (w_last) begin
                    w_next_state = c_IDLE;
                end
            end
            c_DONE: begin
                if (i_abort || i_readout_done) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= c_IDLE;
            r_mode    <= '0;
            r_level   <= '0;
            r_dec     <= '0;
            r_len     <= '0;
            r_prev    <= '0;
            r_dec_cnt <= '0;
            r_count   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_prev  <= i14_data;
            o_busy  <= (w_next_state == c_ARMED) || (w_next_state == c_CAPTURE) ||
                       (w_next_state == c_FLUSH);
            o_done  <= (w_next_state == c_DONE);

            if ((r_state == c_IDLE) && i_arm) begin
                if (i10_window_length != '0) begin
                    r_mode    <= i2_trig_mode;
                    r_level   <= i14_trig_level;
                    r_dec     <= i16_decimation;
                    r_len     <= i10_window_length;
                    r_count   <= '0;
                    o_cfg_err <= 1'b0;
                end else begin
                    o_cfg_err <= 1'b1;
                end
            end else if (w_we) begin
                r_count <= r_count + LEN_W'(1);
            end

            // Strobe fires at count 0; holding 0 while armed aligns the first strobe with entry.
            if (r_state == c_ARMED) begin
                r_dec_cnt <= '0;
            end else if (r_state == c_CAPTURE) begin
                if (r_dec_cnt == w_dec_last) begin
                    r_dec_cnt <= '0;
                end else begin
                    r_dec_cnt <= r_dec_cnt + DECIM_W'(1);
                end
            end
        end
    end

    assign o_we              = w_we;
    assign o_acquire_window  = w_aw;
    assign or10_sample_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_acquisition_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_acquisition_sequencer
// Brief    : Scoreboard bench: stimulus tasks queue the expected strobes,
//            a negedge monitor pops and compares them as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acquisition_sequencer;

    localparam int DECIM_W = 16;
    localparam int LEN_W   = 10;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               i_arm = 1'b0;
    logic               i_abort = 1'b0;
    logic [1:0]         i2_trig_mode = '0;
    logic               i_ext_trigger = 1'b0;
    logic [13:0]        i14_data = '0;
    logic [13:0]        i14_trig_level = '0;
    logic [DECIM_W-1:0] i16_decimation = '0;
    logic [LEN_W-1:0]   i10_window_length = '0;
    logic               i_readout_done = 1'b0;
    logic               o_we;
    logic               o_acquire_window;
    logic               o_busy;
    logic               o_done;
    logic               o_cfg_err;
    logic [LEN_W-1:0]   or10_sample_count;

    acquisition_sequencer #(.DECIM_W(DECIM_W), .LEN_W(LEN_W)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .i_arm             (i_arm),
        .i_abort           (i_abort),
        .i2_trig_mode      (i2_trig_mode),
        .i_ext_trigger     (i_ext_trigger),
        .i14_data          (i14_data),
        .i14_trig_level    (i14_trig_level),
        .i16_decimation    (i16_decimation),
        .i10_window_length (i10_window_length),
        .i_readout_done    (i_readout_done),
        .o_we              (o_we),
        .o_acquire_window  (o_acquire_window),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_cfg_err         (o_cfg_err),
        .or10_sample_count (or10_sample_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit aw;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   data_q[$];
    int   g_prev = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // prev in the model is the sample present in the cycle before, or 0 after reset.
    task automatic tick();
        g_prev = rstn ? int'($signed(i14_data)) : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data();
        int d;
        if (data_q.size() > 0) d = data_q.pop_front();
        else d = int'($urandom_range(400)) - 200;
        i14_data = 14'(d);
    endtask

    task automatic scramble_cfg();
        i2_trig_mode      = 2'($urandom_range(3));
        i14_trig_level    = 14'(int'($urandom_range(400)) - 200);
        i16_decimation    = 16'($urandom_range(9));
        i10_window_length = 10'($urandom_range(20));
    endtask

    task automatic push(input int c, input bit aw, input int k);
        exp_t x;
        x.cyc = c;
        x.aw  = aw;
        x.cnt = k;
        sb_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (o_acquire_window) chk("aw_without_we", int'(o_we), 1);
        if (o_we) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_we_cycle", cyc, -1);
            end else begin
                mon_e = sb_q.pop_front();
                chk("we_cycle", cyc, mon_e.cyc);
                chk("we_acquire_window", int'(o_acquire_window), int'(mon_e.aw));
                chk("we_sample_count", int'(or10_sample_count), mon_e.cnt);
            end
        end
    end

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            i_abort       = 1'($urandom_range(1));
            i_ext_trigger = 1'($urandom_range(1));
            drive_data();
            tick();
            chk("idle_busy", int'(o_busy), 0);
        end
        i_abort = 1'b0;
    endtask

    // One full window: arm, wait for the model-predicted trigger, then strobes.
    task automatic run_capture(input int mode, input int level, input int dec, input int len,
                               input int abort_n, input bit rst_mid, input bit end_abort,
                               output int trig_off);
        int  c, t, d, a, e, na, off, cur;
        bit  trig, done_exp;
        trig_off          = -1;
        i2_trig_mode      = 2'(mode);
        i14_trig_level    = 14'(level);
        i16_decimation    = 16'(dec);
        i10_window_length = 10'(len);
        i_arm             = 1'b1;
        i_abort           = 1'($urandom_range(1));
        drive_data();
        c = cyc;
        tick();
        i_arm   = 1'b0;
        i_abort = 1'b0;
        chk("armed_busy", int'(o_busy), 1);
        chk("arm_clears_cfg_err", int'(o_cfg_err), 0);
        chk("arm_clears_count", int'(or10_sample_count), 0);

        d    = (dec == 0) ? 1 : dec;
        trig = 1'b0;
        t    = -1;
        for (int i = 0; i < 300 && !trig; i++) begin
            if (i > 0) chk("armed_busy_hold", int'(o_busy), 1);
            scramble_cfg();
            drive_data();
            i_ext_trigger = ($urandom_range(7) == 0);
            cur = int'($signed(i14_data));
            case (mode)
                0:       trig = 1'b1;
                1:       trig = (g_prev < level) && (cur >= level);
                2:       trig = (g_prev > level) && (cur <= level);
                default: trig = i_ext_trigger;
            endcase
            if (trig) t = cyc;
            else tick();
        end
        if (!trig) begin
            chk("trigger_timeout", 0, 1);
            i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
            return;
        end
        trig_off = t - c;

        na = (abort_n > 0) ? abort_n : len;
        a  = -1;
        done_exp = 1'b1;
        e  = t + 1 + (len - 1) * d + 1;
        if (rst_mid) begin
            push(t + 1, 1'b1, 0);
        end else begin
            for (int k = 0; k < na; k++) push(t + 1 + k * d, (k == 0), k);
            if (abort_n > 0) begin
                off = (abort_n == len) ? 0 : int'($urandom_range(d - 1));
                a   = t + 1 + (abort_n - 1) * d + off;
                if (abort_n < len) begin
                    for (int k = na; k < len; k++) push(a + 1 + (k - na), 1'b0, k);
                    e        = a + 1 + (len - na);
                    done_exp = 1'b0;
                end
            end
        end
        tick();

        if (rst_mid) begin
            chk("capture_busy", int'(o_busy), 1);
            drive_data();
            tick();
            rstn = 1'b0;
            tick();
            chk("rst_we", int'(o_we), 0);
            chk("rst_aw", int'(o_acquire_window), 0);
            chk("rst_busy", int'(o_busy), 0);
            chk("rst_done", int'(o_done), 0);
            chk("rst_cfg_err", int'(o_cfg_err), 0);
            chk("rst_count", int'(or10_sample_count), 0);
            chk("rst_sb_drained", sb_q.size(), 0);
            rstn = 1'b1;
            return;
        end

        while (cyc < e) begin
            chk("capture_busy", int'(o_busy), 1);
            chk("capture_not_done", int'(o_done), 0);
            i_abort = (cyc == a) || ((a >= 0) && (cyc > a) && ($urandom_range(3) == 0));
            drive_data();
            scramble_cfg();
            tick();
        end
        i_abort = 1'b0;
        chk("end_busy", int'(o_busy), 0);
        chk("end_done", int'(o_done), int'(done_exp));
        chk("end_count", int'(or10_sample_count), len);
        chk("sb_drained", sb_q.size(), 0);

        if (done_exp) begin
            i_arm = 1'b1;
            tick();
            i_arm = 1'b0;
            chk("done_arm_ignored_done", int'(o_done), 1);
            chk("done_arm_ignored_busy", int'(o_busy), 0);
            chk("done_count_hold", int'(or10_sample_count), len);
            if (end_abort) i_abort = 1'b1;
            else i_readout_done = 1'b1;
            tick();
            i_abort        = 1'b0;
            i_readout_done = 1'b0;
            chk("released_done", int'(o_done), 0);
            chk("released_busy", int'(o_busy), 0);
            chk("idle_count_readable", int'(or10_sample_count), len);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int off;
        int len, na;

        rstn = 1'b0;
        tick();
        tick();
        chk("reset_we", int'(o_we), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        chk("reset_cfg_err", int'(o_cfg_err), 0);
        chk("reset_count", int'(or10_sample_count), 0);
        rstn = 1'b1;
        idle_gap(3);

        run_capture(0, 0, 1, 4, 0, 1'b0, 1'b0, off);
        chk("immediate_trig_offset", off, 1);
        idle_gap(2);

        data_q = '{150, 150, 150, 90, 95, 100, 105};
        run_capture(1, 100, 1, 3, 0, 1'b0, 1'b0, off);
        chk("rise_trig_offset", off, 5);
        idle_gap(2);

        run_capture(0, 0, 5, 3, 0, 1'b0, 1'b0, off);
        run_capture(0, 0, 0, 4, 0, 1'b0, 1'b1, off);
        run_capture(0, 0, 4, 8, 2, 1'b0, 1'b0, off);
        idle_gap(2);
        run_capture(0, 0, 3, 5, 5, 1'b0, 1'b0, off);

        i10_window_length = '0;
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        chk("len0_stays_idle", int'(o_busy), 0);
        chk("len0_cfg_err", int'(o_cfg_err), 1);
        idle_gap(1);
        chk("cfg_err_sticky", int'(o_cfg_err), 1);
        run_capture(0, 0, 2, 2, 0, 1'b0, 1'b0, off);

        run_capture(0, 0, 3, 5, 0, 1'b1, 1'b0, off);
        idle_gap(2);

        data_q = '{-40, -60};
        run_capture(2, -50, 1, 2, 0, 1'b0, 1'b0, off);
        chk("fall_trig_offset", off, 1);

        i2_trig_mode = 2'b11; i10_window_length = 10'd4; i16_decimation = 16'd1;
        i_ext_trigger = 1'b0; i_abort = 1'b0; i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ext_wait_busy", int'(o_busy), 1);
            i_ext_trigger = 1'b0;
            drive_data();
            tick();
        end
        i_ext_trigger = 1'b1;
        i_abort       = 1'b1;
        tick();
        i_abort       = 1'b0;
        i_ext_trigger = 1'b0;
        chk("armed_abort_beats_trig", int'(o_busy), 0);
        idle_gap(4);

        i2_trig_mode = 2'b11; i10_window_length = 10'd4; i_arm = 1'b1; i_abort = 1'b1;
        i_ext_trigger = 1'b0;
        tick();
        i_arm = 1'b0; i_abort = 1'b0;
        chk("arm_beats_abort", int'(o_busy), 1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("armed_abort", int'(o_busy), 0);
        idle_gap(3);

        for (int n = 0; n < 40; n++) begin
            len = int'($urandom_range(1, 12));
            na  = ($urandom_range(2) == 0) ? int'($urandom_range(1, len)) : 0;
            run_capture(int'($urandom_range(3)), int'($urandom_range(200)) - 100,
                        int'($urandom_range(6)), len, na, 1'b0, 1'($urandom_range(1)), off);
            idle_gap(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acquisition_sequencer.md
Name: acquisition_sequencer

Overview:
Sequences one ADC window capture into the BRAM-writer block. The block arms on a processor request and waits for a trigger (immediate, level-crossing or external). It then issues decimated write strobes plus a start-of-window pulse to the writer, and holds a done flag until the processor acknowledges readout. An aborted capture is flushed to the end of the window so that the writer's address counter always returns to zero.

Parameters:
DECIM_W, 16, width of decimation ratio input
LEN_W, 10, width of window length input and sample counter

Ports:
clk  in  1  system clock, also the ADC sample clock
rstn  in  1  synchronous active-low reset
i_arm  in  1  single-cycle arm request
i_abort  in  1  single-cycle abort request
i2_trig_mode  in  2  trigger mode: 00 immediate, 01 rising level, 10 falling level, 11 external
i_ext_trigger  in  1  external trigger, already synchronised to clk
i14_data  in  14  ADC sample, two's complement
i14_trig_level  in  14  trigger threshold, two's complement
i16_decimation  in  DECIM_W  clocks per strobe; 0 is treated as 1
i10_window_length  in  LEN_W  samples per window; 0 is invalid
i_readout_done  in  1  single-cycle acknowledge that the processor has read the BRAM
o_we  out  1  write strobe to writer, one cycle wide
o_acquire_window  out  1  start-of-window pulse, coincident with the first o_we
o_busy  out  1  high in ARMED, CAPTURE and FLUSH
o_done  out  1  high in DONE
o_cfg_err  out  1  sticky: arm was rejected because the window length was 0
or10_sample_count  out  LEN_W  number of strobes issued in the current window

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE. All outputs 0, decimation counter 0, latched configuration 0, previous-sample register 0. Reset mid-capture abandons the capture with no flush.
- Configuration (mode, level, decimation, length) is latched on an accepted arm. Input changes after that are ignored until the next arm.
- IDLE: i_arm with length≠0 → ARMED, and o_cfg_err clears. i_arm with length=0 → remain IDLE, o_cfg_err sets.
- ARMED, trigger evaluated every clk:
  - mode 00: fires on the first ARMED cycle.
  - mode 01: prev<level && cur>=level.
  - mode 10: prev>level && cur<=level.
  - mode 11: i_ext_trigger=1.
  - Comparisons are signed 14-bit. prev is the sample registered on the previous clk and is updated in every state.
  - Trigger at cycle N → CAPTURE at N+1.
- CAPTURE:
  - First o_we and o_acquire_window are asserted on the first CAPTURE cycle; then one o_we every max(decimation,1) clks.
  - or10_sample_count increments on each o_we, one cycle after it.
  - When the strobe with count==length-1 issues → DONE on the next cycle, and or10_sample_count equals the latched length.
- FLUSH (entered from CAPTURE on i_abort):
  - o_we is asserted every clk with no decimation until count reaches length, then → IDLE, not DONE.
  - o_acquire_window is never asserted in FLUSH.
- i_abort in ARMED or DONE → IDLE next cycle, with no strobes. i_abort in IDLE or FLUSH is ignored.
- DONE: o_done=1. i_readout_done → IDLE next cycle. i_arm in DONE is ignored.
- Simultaneous events:
  - i_arm and i_abort together in IDLE: arm wins.
  - In ARMED, a trigger and i_abort on the same cycle: abort wins, no strobe.
  - In CAPTURE, the final strobe and i_abort on the same cycle: the strobe issues and the next state is DONE.
- Decimation counter: reloads to 0 on every strobe and on CAPTURE entry. Width DECIM_W, no wrap possible because it reloads at max(dec,1)-1.
- or10_sample_count clears on an accepted arm only, so it remains readable in DONE and IDLE.
- o_busy and o_done are registered outputs decoded from the state and change in the same cycle as the state.

Test Plan:
- Immediate mode, length=4, decimation=1: arm at cycle 0 → ARMED at 1, o_we at 2,3,4,5; o_acquire_window only at 2; o_done from 6; i_readout_done → IDLE.
- Rising mode, level=100, data ramp 90,95,100,105: trigger on the 100 sample; first o_we one cycle later; data stream 150,150 with prev=150 causes no trigger.
- Decimation=5, length=3: o_we spaced exactly 5 clks apart; count=3 at done; decimation=0 gives spacing 1.
- Abort after 2 of 8 strobes (decimation=4) → FLUSH issues 6 back-to-back o_we, then IDLE; o_done never set; o_acquire_window is not re-asserted.
- Length=0 arm → stays IDLE, o_cfg_err=1; then arm with length=2 → o_cfg_err=0 and capture proceeds; arm in DONE is ignored.
- Reset asserted mid-CAPTURE → next cycle all outputs 0, state IDLE; falling mode with level=-50 triggers on the signed transition -40 → -60.
